// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-add multiplier that borrows an external ALU for
// its adds: one add-then-shift step per cycle, eight steps, then a done pulse.
`ifndef OP_ADD
`define OP_ADD 4'b0000
`endif

module alu_mul_seq #(
  parameter logic [3:0] ADD_CODE = `OP_ADD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [15:0] p_q, p_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic [15:0] p_step;

  // Upper byte of P is the running partial sum; the lower byte shifts the
  // multiplier out LSB-first, so P[0] always selects the current addend.
  assign p_step = {alu_carry, alu_result, p_q[7:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          p_d     = {8'h00, multiplier};
          cnt_d   = 3'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = S_DONE;
          product_d = p_step;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= 8'h00;
      p_q       <= 16'h0000;
      cnt_q     <= 3'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign alu_op  = ADD_CODE;
  assign alu_a   = busy ? p_q[15:8] : 8'h00;
  assign alu_b   = (busy && p_q[0]) ? m_q : 8'h00;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have parameter ADD_CODE, default `OP_ADD from the shared defines header, giving the 4-bit ALU add opcode driven on alu_op.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin a multiply, sampled on the rising edge of clk.
REQ-005 The block SHALL have port multiplicand  input  8  unsigned operand A, captured when start is accepted.
REQ-006 The block SHALL have port multiplier  input  8  unsigned operand B, captured when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking a valid product.
REQ-009 The block SHALL have port product  output  16  unsigned A*B, held until the next completion.
REQ-010 The block SHALL have port alu_op  output  4  opcode to the shared ALU.
REQ-011 The block SHALL have port alu_a  output  8  ALU operand1.
REQ-012 The block SHALL have port alu_b  output  8  ALU operand2.
REQ-013 The block SHALL have port alu_result  input  8  ALU result.
REQ-014 The block SHALL have port alu_carry  input  1  ALU carry_flag.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-016 In IDLE with start=1, the block SHALL capture the multiplicand into register M, load the 16-bit accumulator P={8'h00, multiplier}, clear the 3-bit iteration counter, and enter RUN.
REQ-017 start SHALL be ignored in RUN and in DONE, with no operand capture and no effect on the operation in flight.
REQ-018 In RUN, the block SHALL drive alu_op=ADD_CODE, alu_a=P[15:8], and alu_b=(P[0] ? M : 8'h00) combinationally.
REQ-019 At each RUN edge, the block SHALL update P to {alu_carry, alu_result, P[7:1]} (add-then-shift-right, carry retained as bit 15) and increment the counter.
REQ-020 The block SHALL perform exactly 8 RUN iterations regardless of operand values; after the edge completing iteration 8 (counter wrap 7->0), the state SHALL be DONE.
REQ-021 On entry to DONE, the block SHALL load product from P; done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-022 Latency SHALL be fixed: if start is sampled at edge t, done is high in the cycle following edge t+8, and busy is high in the cycles following edges t through t+7.
REQ-023 Outside RUN, the block SHALL drive alu_op=ADD_CODE, alu_a=8'h00, and alu_b=8'h00.
REQ-024 product SHALL change only on entry to DONE and SHALL otherwise hold its last value.
REQ-025 The carry from an 8-bit add with full operands (e.g. 0xFF+0xFF) SHALL propagate into bit 15 with no loss; the final product SHALL always be bit-exact A*B in 16 bits.
REQ-026 The block SHALL use no flag other than alu_carry.

Reset
REQ-027 The rst_n=0 assertion SHALL act immediately, independent of clk, and place the block in IDLE with P=0, M=0, counter=0, product=16'h0000, busy=0, done=0.
REQ-028 A reset asserted in RUN or DONE SHALL abort the operation with no done pulse and no product update; the first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-029 The bench SHALL apply start with A=13, B=11 -> busy high for 8 cycles, then done for one cycle with product=16'h008F.
REQ-030 The bench SHALL apply A=255, B=255 -> product=16'hFE01; internal carry into bit 15 is exercised.
REQ-031 The bench SHALL apply A=0, B=200 and then A=200, B=0 -> product=16'h0000 in each case, with latency still 8 cycles to done.
REQ-032 The bench SHALL start A=3, B=5, then hold start=1 with A=7, B=7 through RUN and DONE -> product=16'h000F; the second request is accepted only once IDLE is reached, giving product=16'h0031.
REQ-033 The bench SHALL start A=9, B=9 and pull rst_n low after 4 RUN cycles -> busy=0, done=0, and product=16'h0000 immediately; there is no done pulse afterward until a new start.
REQ-034 The bench SHALL check throughout that, in every RUN cycle, alu_a equals P[15:8] and alu_b equals M or 0 according to P[0], and that alu_op always equals ADD_CODE.
